// File: rtl/sel_mux_buf_if.sv
// sel_mux_buf_if: producer/consumer handshake bundle for sel_mux_buf.
// slave = block side, master = driver side.
interface sel_mux_buf_if #(
  parameter int WL  = 32,
  parameter int NCH = 4,
  parameter int SW  = $clog2(NCH)
);
  logic [SW-1:0]     sel;
  logic [NCH*WL-1:0] in_bus;
  logic              in_valid;
  logic              in_ready;
  logic [WL-1:0]     out_data;
  logic [SW-1:0]     out_sel;
  logic              out_valid;
  logic              out_ready;
  logic              sel_err;
  logic              err_clr;

  modport slave (
    input  sel,
    input  in_bus,
    input  in_valid,
    input  out_ready,
    input  err_clr,
    output in_ready,
    output out_data,
    output out_sel,
    output out_valid,
    output sel_err
  );

  modport master (
    output sel,
    output in_bus,
    output in_valid,
    output out_ready,
    output err_clr,
    input  in_ready,
    input  out_data,
    input  out_sel,
    input  out_valid,
    input  sel_err
  );
endinterface

// File: rtl/sel_mux_buf.sv
// sel_mux_buf: registered NCH-way word select into a 2-entry FIFO.
// Ports: clk, rst_n (async low), b (sel_mux_buf_if.slave).
module sel_mux_buf #(
  parameter int WL  = 32,
  parameter int NCH = 4,
  parameter int SW  = $clog2(NCH)
) (
  input logic          clk,
  input logic          rst_n,
  sel_mux_buf_if.slave b
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } st_t;

  localparam logic [SW:0] NCHW = (SW+1)'(NCH);

  st_t           st;
  logic [WL-1:0] head_d;
  logic [SW-1:0] head_s;
  logic [WL-1:0] tail_d;
  logic [SW-1:0] tail_s;
  logic          ir_q;
  logic          ov_q;
  logic          err_q;

  logic          acc;
  logic          pop;
  logic          oor;
  logic [WL-1:0] word;

  assign acc = b.in_valid && ir_q;
  assign pop = ov_q && b.out_ready;
  assign oor = ({1'b0, b.sel} >= NCHW);

  // Out-of-range selects match no channel and fall through to zero.
  always_comb begin
    word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (b.sel == SW'(k)) begin
        word = b.in_bus[k*WL +: WL];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= EMPTY;
      head_d <= '0;
      head_s <= '0;
      tail_d <= '0;
      tail_s <= '0;
      ir_q   <= 1'b1;
      ov_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (acc && oor) begin
        err_q <= 1'b1;
      end else if (b.err_clr) begin
        err_q <= 1'b0;
      end
      unique case (st)
        EMPTY: begin
          if (acc) begin
            head_d <= word;
            head_s <= b.sel;
            ov_q   <= 1'b1;
            st     <= ONE;
          end
        end
        ONE: begin
          if (acc && !pop) begin
            tail_d <= word;
            tail_s <= b.sel;
            ir_q   <= 1'b0;
            st     <= FULL;
          end else if (!acc && pop) begin
            ov_q <= 1'b0;
            st   <= EMPTY;
          end else if (acc && pop) begin
            head_d <= word;
            head_s <= b.sel;
          end
        end
        FULL: begin
          if (pop) begin
            head_d <= tail_d;
            head_s <= tail_s;
            ir_q   <= 1'b1;
            st     <= ONE;
          end
        end
        default: begin
          st   <= EMPTY;
          ir_q <= 1'b1;
          ov_q <= 1'b0;
        end
      endcase
    end
  end

  assign b.in_ready  = ir_q;
  assign b.out_valid = ov_q;
  assign b.out_data  = head_d;
  assign b.out_sel   = head_s;
  assign b.sel_err   = err_q;

endmodule

// File: tb/tb_sel_mux_buf.sv
// tb_sel_mux_buf: drives NCH=4 and NCH=3 instances in lockstep,
// checks both against a queue-based reference model.
module tb_sel_mux_buf;

  logic clk;
  logic rst_n;

  sel_mux_buf_if #(.WL(32), .NCH(4), .SW(2)) b4 ();
  sel_mux_buf_if #(.WL(32), .NCH(3), .SW(2)) b3 ();

  sel_mux_buf #(.WL(32), .NCH(4), .SW(2)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .b     (b4.slave)
  );

  sel_mux_buf #(.WL(32), .NCH(3), .SW(2)) u3 (
    .clk   (clk),
    .rst_n (rst_n),
    .b     (b3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d4;
    logic [31:0] d3;
    logic [1:0]  s;
  } ent_t;

  ent_t        q[$];
  logic        err4;
  logic        err3;
  logic [31:0] ch[4];
  int          total;
  int          passed;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(logic v, logic [1:0] s, logic rdy, logic clr);
    logic [127:0] bus;
    for (int k = 0; k < 4; k++) bus[k*32 +: 32] = ch[k];
    b4.in_valid  = v;
    b3.in_valid  = v;
    b4.sel       = s;
    b3.sel       = s;
    b4.out_ready = rdy;
    b3.out_ready = rdy;
    b4.err_clr   = clr;
    b3.err_clr   = clr;
    b4.in_bus    = bus;
    b3.in_bus    = bus[95:0];
  endtask

  task automatic check_all(string tag);
    bit nf;
    bit ne;
    nf = (q.size() != 2);
    ne = (q.size() != 0);
    chk({tag, " ir4"}, 32'(b4.in_ready), 32'(nf));
    chk({tag, " ir3"}, 32'(b3.in_ready), 32'(nf));
    chk({tag, " ov4"}, 32'(b4.out_valid), 32'(ne));
    chk({tag, " ov3"}, 32'(b3.out_valid), 32'(ne));
    chk({tag, " err4"}, 32'(b4.sel_err), 32'(err4));
    chk({tag, " err3"}, 32'(b3.sel_err), 32'(err3));
    if (ne) begin
      chk({tag, " d4"}, b4.out_data, q[0].d4);
      chk({tag, " d3"}, b3.out_data, q[0].d3);
      chk({tag, " s4"}, 32'(b4.out_sel), 32'(q[0].s));
      chk({tag, " s3"}, 32'(b3.out_sel), 32'(q[0].s));
    end
  endtask

  task automatic check_reset(string tag);
    check_all(tag);
    chk({tag, " rd4"}, b4.out_data, 32'h0);
    chk({tag, " rd3"}, b3.out_data, 32'h0);
    chk({tag, " rs4"}, 32'(b4.out_sel), 32'h0);
    chk({tag, " rs3"}, 32'(b3.out_sel), 32'h0);
  endtask

  // One clock of the reference: FIFO of 2, pop before push.
  task automatic step(string tag);
    bit   acc;
    bit   pop;
    ent_t e;
    int   s;
    s    = int'(b4.sel);
    acc  = b4.in_valid && (q.size() != 2);
    pop  = b4.out_ready && (q.size() != 0);
    e.d4 = ch[s];
    e.d3 = (s < 3) ? ch[s] : 32'h0;
    e.s  = b4.sel;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(e);
    if (b4.err_clr) begin
      err4 = 1'b0;
      err3 = 1'b0;
    end
    if (acc && s >= 3) err3 = 1'b1;
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    err4 = 1'b0;
    err3 = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    for (int k = 0; k < 4; k++) ch[k] = 32'h0;
    model_reset();
    rst_n = 1'b0;
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    ch[2] = 32'hDEADBEEF;
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    step("basic");
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    step("basic_drain");

    for (int k = 0; k < 4; k++) ch[k] = 32'h1000 + k;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'(i % 4), 1'b1, 1'b0);
      step("stream");
    end
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    step("stream_drain");

    ch[0] = 32'hA; ch[1] = 32'hB; ch[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'(i), 1'b0, 1'b0);
      step("bp_fill");
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd2, 1'b1, 1'b0);
      step("bp_drain");
    end
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    repeat (2) step("bp_tail");

    ch[0] = 32'h11; ch[1] = 32'h22;
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    step("ap_head");
    drive(1'b1, 2'd1, 1'b1, 1'b0);
    step("ap_both");
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    step("ap_drain");

    ch[3] = 32'h3333;
    drive(1'b1, 2'd3, 1'b1, 1'b0);
    step("oor");
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    step("oor_sticky");
    drive(1'b0, 2'd0, 1'b1, 1'b1);
    step("oor_clr");
    drive(1'b1, 2'd3, 1'b1, 1'b0);
    step("oor_set");
    drive(1'b1, 2'd3, 1'b1, 1'b1);
    step("oor_set_clr");
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    step("oor_drain");

    ch[0] = 32'hBAD0; ch[1] = 32'hBAD1;
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    step("rf_fill0");
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    step("rf_fill1");
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset("rf_async");
    #1;
    rst_n = 1'b1;
    ch[2] = 32'h600D;
    drive(1'b1, 2'd2, 1'b1, 1'b0);
    step("rf_new");
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    step("rf_drain");

    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) ch[k] = $urandom;
      drive(1'($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 9) == 0));
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
